// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: frame format, receiver states and per-frame status.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } rx_status_t;

  // Parity bit a well-formed frame carries, given the XOR of its data bits.
  function automatic logic expected_parity(input parity_t mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count and pop-while-empty error pulse.
// Push while full is dropped unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             error_q, error_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign error     = error_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    error_d  = pop && empty;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

`ifndef SYNTHESIS
  a_error_from_empty_pop: assert property (@(posedge clk) disable iff (!rst)
    error |-> $past(pop && empty));
  a_level_bound: assert property (@(posedge clk) disable iff (!rst)
    level <= DEPTH);
`endif

endmodule

// File: rtl/uart_rx_queue.sv
// UART receiver: two-flop rx synchroniser, mid-bit sampling frame FSM, and a FWFT queue of
// {frame_err, parity_err, data} entries with sticky overrun for frames lost while full.
module uart_rx_queue
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 12_000_000,
  parameter int      BAUD      = 9_600,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PAR_NONE,
  parameter int      DEPTH     = 16,
  parameter bit      DROP_BAD  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic                       pop_front,
  output logic [DATA_BITS-1:0]       data_out,
  output logic [1:0]                 status_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic                       error
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int EW  = DATA_BITS + 2;

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push_q, push_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 frame_lost;
  rx_status_t           entry_status;
  logic [EW-1:0]        entry;
  logic [EW-1:0]        head;

  // Counter runs down to 1 and reloads a full bit period, so each tick lands mid-bit.
  assign tick = (cnt_q == CW'(1));

  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    state_d      = state_q;
    cnt_d        = tick ? CW'(CPB) : cnt_q - CW'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    push_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (rx_prev_q && !rx_sync_q) begin
          state_d      = ST_START;
          cnt_d        = CW'(CPB / 2);
          bit_cnt_d    = '0;
          parity_err_d = 1'b0;
          frame_err_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tick) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          parity_err_d = (rx_sync_q != expected_parity(PARITY, ^shift_q));
          state_d      = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          frame_err_d = !rx_sync_q;
          push_d      = !(DROP_BAD && (!rx_sync_q || parity_err_q));
          state_d     = rx_sync_q ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q;
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A frame is lost only when the queue is full and no pop frees a slot this cycle.
  always_comb begin
    frame_lost = push_q && full && !(pop_front && !empty);
    overrun_d  = frame_lost || (overrun_q && !clr_overrun);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      push_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      push_q       <= push_d;
      overrun_q    <= overrun_d;
    end
  end

  assign entry_status = '{frame_err: frame_err_q, parity_err: parity_err_q};
  assign entry        = {entry_status, shift_q};

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (entry),
    .pop       (pop_front),
    .head_data (head),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .error     (error)
  );

  assign data_out   = head[DATA_BITS-1:0];
  assign status_out = head[EW-1:DATA_BITS];
  assign overrun    = overrun_q;

endmodule
